alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//   Operand-fetch stage directly upstream of the ALU. It holds the architectural register file
//   (2 read ports, 1 write port) and reads rs1/rs2 for each issued op, with same-cycle writeback bypass.
//   It registers input_1, input_2 and alu_control into a valid/ready output slot.
//   The output ports wire straight to alu.input_1 / alu.input_2 / alu.alu_control.
// PARAMETERS
//   DATA_W    32  operand / register width
//   NUM_REGS  32  register count; register 0 reads as zero
//   ADDR_W    5   register address width, equal to $clog2(NUM_REGS)
//   CTRL_W    2   ALU control width
// PORTS
//   clk           in   1       rising-edge clock, the only clock
//   reset         in   1       synchronous, active-high reset
//   issue_valid   in   1       upstream presents an op
//   issue_ready   out  1       stage can accept an op this cycle
//   rs1_addr      in   ADDR_W  source register for input_1
//   rs2_addr      in   ADDR_W  source register for input_2
//   alu_ctrl_in   in   CTRL_W  ALU opcode, passed through
//   wb_en         in   1       writeback enable
//   wb_addr       in   ADDR_W  writeback destination
//   wb_data       in   DATA_W  writeback value
//   input_1       out  DATA_W  operand A to ALU (registered)
//   input_2       out  DATA_W  operand B to ALU (registered)
//   alu_control   out  CTRL_W  opcode to ALU (registered)
//   op_valid      out  1       output slot holds a valid op
//   op_ready      in   1       downstream consumes the op this cycle
// BEHAVIOUR
//   - Reset (sync, active-high): op_valid=0; input_1=0, input_2=0, alu_control=0; all registers cleared to 0.
//     Reset wins over a same-cycle issue and writeback.
//   - Reads are combinational from the register array:
//     rsN==0 -> 0;
//     else if wb_en && wb_addr==rsN -> wb_data (bypass);
//     else array[rsN].
//   - Write: at the clock edge, if wb_en && wb_addr!=0 then array[wb_addr]<=wb_data. Writes to r0 are dropped.
//   - issue_ready = !op_valid || op_ready (combinational; no combinational path from issue_valid).
//   - Accept = issue_valid && issue_ready. On accept, the bypassed operands and alu_ctrl_in load the
//     output regs at the next edge. Latency is 1 cycle from issue to op_valid.
//   - Slot next-state: accept -> op_valid=1; else op_valid && op_ready -> op_valid=0; else hold.
//     A consume plus a new accept in the same cycle gives back-to-back issue at full throughput.
//   - Stall (op_valid && !op_ready): input_1, input_2 and alu_control stay bit-stable.
//     Later writebacks do NOT update operands already captured. Hazard ordering is the issuer's job.
//   - When no op is accepted, the output regs hold their last values (no clearing on consume).
//   - Arithmetic: none; values pass through at full DATA_W, with no extension.
// STRUCTURE
//   - Shared package alu_pkg: DATA_W, ADDR_W, CTRL_W constants; ALU opcode localparams 2'b00..2'b11;
//     zero-register index.
//   - Sub-module reg_file: 2R1W array with reset clear, r0 hardwiring and write-to-read bypass.
//   - Top level: handshake logic plus the output pipeline register.
// TESTING
//   1. Reset held 2 cycles -> op_valid=0, input_1=input_2=0, alu_control=0; read of any reg returns 0.
//   2. Write r3=23, r4=42; issue rs1=3, rs2=4, ctrl=2'b10 with op_ready=1
//      -> next cycle op_valid=1, input_1=23, input_2=42, alu_control=2'b10.
//   3. Same-cycle bypass: wb r5=0xDEADBEEF while issuing rs1=5
//      -> input_1=0xDEADBEEF. Then wb r0=7 and issue rs2=0 -> input_2=0.
//   4. Backpressure: op_ready=0 for 3 cycles with issue_valid=1
//      -> issue_ready=0; outputs stable; a wb to the held source reg leaves input_1 unchanged.
//      Raise op_ready -> the pending op is accepted in the same cycle.
//   5. Throughput: 4 ops back-to-back with op_ready=1 -> 4 consecutive op_valid cycles in issue order,
//      e.g. ctrl 00, 01, 10, 11 with 23/42 operands.
//   6. Reset mid-operation: assert reset while op_valid=1 and wb_en=1 -> next cycle op_valid=0,
//      the written reg reads 0, and the issue after reset gets fresh values.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, opcode encodings and the zero-register index for the
// ALU operand-fetch stage and its register file.
package alu_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int CTRL_W   = 2;

  // Register 0 is hardwired to zero: reads return 0 and writes are dropped.
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  // ALU opcode encodings; the stage passes them through untouched.
  typedef enum logic [CTRL_W-1:0] {
    ALU_CTRL_00 = 2'b00,
    ALU_CTRL_01 = 2'b01,
    ALU_CTRL_10 = 2'b10,
    ALU_CTRL_11 = 2'b11
  } alu_ctrl_e;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one write
// port, r0 hardwired to zero, and same-cycle writeback-to-read bypass.
module reg_file
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage update: synchronous clear of every register, otherwise write non-r0 targets.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array is reset on purpose because every register must read 0
      // after reset; this keeps it in flops rather than an inferred RAM.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != ZERO_REG) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      regs[wr_addr] <= wr_data;
    end
  end

  // Read port A: r0 -> zero, then bypass a same-cycle writeback, else storage.
  always_comb begin
    // NOTE: a default on entry means every path assigns the output, so no latch.
    rd_data_a = regs[rd_addr_a];
    if (rd_addr_a == ZERO_REG)                rd_data_a = '0;
    else if (wr_en && wr_addr == rd_addr_a)   rd_data_a = wr_data;
  end

  // Read port B: same priority as port A.
  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (rd_addr_b == ZERO_REG)                rd_data_b = '0;
    else if (wr_en && wr_addr == rd_addr_b)   rd_data_b = wr_data;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage in front of the ALU: reads rs1/rs2 (with writeback
// bypass) and captures operands plus opcode into a valid/ready output slot.
module alu_operand_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [CTRL_W-1:0] alu_ctrl_in,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] input_1,
  output logic [DATA_W-1:0] input_2,
  output logic [CTRL_W-1:0] alu_control,
  output logic              op_valid,
  input  logic              op_ready
);

  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              accept;

  reg_file u_reg_file (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (rs1_addr),
    .rd_data_a (rs1_data),
    .rd_addr_b (rs2_addr),
    .rd_data_b (rs2_data),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data)
  );

  // The slot can take a new op when empty or when its current op leaves this cycle.
  assign issue_ready = !op_valid || op_ready;
  assign accept      = issue_valid && issue_ready;

  // Output slot: load on accept, drain on consume, otherwise hold operands bit-stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_valid    <= 1'b0;
      input_1     <= '0;
      input_2     <= '0;
      alu_control <= ALU_CTRL_00;
    end else if (accept) begin
      op_valid    <= 1'b1;
      input_1     <= rs1_data;
      input_2     <= rs2_data;
      alu_control <= alu_ctrl_in;
    end else if (op_ready) begin
      op_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: a table of single-cycle issue
// vectors plus directed sequences for backpressure, throughput and reset.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [1:0]  alu_ctrl_in;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] input_1;
  logic [31:0] input_2;
  logic [1:0]  alu_control;
  logic        op_valid;
  logic        op_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .alu_ctrl_in (alu_ctrl_in),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .input_1     (input_1),
    .input_2     (input_2),
    .alu_control (alu_control),
    .op_valid    (op_valid),
    .op_ready    (op_ready)
  );

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  ctrl;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [1:0] c, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ordy);
    issue_valid = iv;
    rs1_addr    = r1;
    rs2_addr    = r2;
    alu_ctrl_in = c;
    wb_en       = we;
    wb_addr     = wa;
    wb_data     = wd;
    op_ready    = ordy;
  endtask

  task automatic check_slot(input string tag, input logic v, input logic [31:0] a,
                            input logic [31:0] b, input logic [1:0] c);
    check({tag, ".op_valid"},    {31'd0, op_valid}, {31'd0, v});
    check({tag, ".input_1"},     input_1, a);
    check({tag, ".input_2"},     input_2, b);
    check({tag, ".alu_control"}, {30'd0, alu_control}, {30'd0, c});
  endtask

  initial begin
    // Register state evolves across rows: r3=23, r4=42, r5=DEADBEEF, then r3=FFFFFFFF.
    vecs[0] = '{1'b1, 5'd3, 32'd23,         5'd31, 5'd17, 2'b01, 32'd0,          32'd0};
    vecs[1] = '{1'b1, 5'd4, 32'd42,         5'd3,  5'd1,  2'b00, 32'd23,         32'd0};
    vecs[2] = '{1'b0, 5'd0, 32'd0,          5'd3,  5'd4,  2'b10, 32'd23,         32'd42};
    vecs[3] = '{1'b1, 5'd5, 32'hDEADBEEF,   5'd5,  5'd3,  2'b11, 32'hDEADBEEF,   32'd23};
    vecs[4] = '{1'b1, 5'd0, 32'd7,          5'd5,  5'd0,  2'b01, 32'hDEADBEEF,   32'd0};
    vecs[5] = '{1'b0, 5'd0, 32'd0,          5'd0,  5'd5,  2'b00, 32'd0,          32'hDEADBEEF};
    vecs[6] = '{1'b1, 5'd3, 32'hFFFFFFFF,   5'd3,  5'd3,  2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF};
    vecs[7] = '{1'b0, 5'd0, 32'd0,          5'd3,  5'd4,  2'b10, 32'hFFFFFFFF,   32'd42};

    // Reset held for two cycles with activity on the inputs.
    reset = 1'b1;
    drive(1'b1, 5'd3, 5'd4, 2'b11, 1'b1, 5'd3, 32'd99, 1'b1);
    step();
    step();
    reset = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    check_slot("reset", 1'b0, 32'd0, 32'd0, 2'b00);
    check("reset.issue_ready", {31'd0, issue_ready}, 32'd1);

    // Empty slot with no issue stays empty.
    step();
    check("idle.op_valid", {31'd0, op_valid}, 32'd0);

    // Table: one issue per cycle with writeback alongside, consumer always ready.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].rs1, vecs[i].rs2, vecs[i].ctrl,
            vecs[i].wb_en, vecs[i].wb_addr, vecs[i].wb_data, 1'b1);
      step();
      check_slot($sformatf("vec%0d", i), 1'b1, vecs[i].exp1, vecs[i].exp2, vecs[i].ctrl);
    end

    // Backpressure: slot holds {FFFFFFFF, 42, 10}; a new op waits, and a wb to r3
    // (the held op's rs1) must not disturb the captured operand.
    drive(1'b1, 5'd3, 5'd4, 2'b01, 1'b1, 5'd3, 32'h12345678, 1'b0);
    #1;
    check("stall.issue_ready", {31'd0, issue_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      wb_en = 1'b0;
      check_slot($sformatf("stall%0d", i), 1'b1, 32'hFFFFFFFF, 32'd42, 2'b10);
      check($sformatf("stall%0d.issue_ready", i), {31'd0, issue_ready}, 32'd0);
    end
    op_ready = 1'b1;
    #1;
    check("release.issue_ready", {31'd0, issue_ready}, 32'd1);
    step();
    check_slot("release", 1'b1, 32'h12345678, 32'd42, 2'b01);

    // Throughput: four back-to-back ops, each visible on the following cycle.
    for (int i = 0; i < 4; i++) begin
      logic [4:0]  a;
      logic [4:0]  b;
      logic [31:0] ea;
      logic [31:0] eb;
      a  = (i % 2 == 0) ? 5'd3 : 5'd4;
      b  = (i % 2 == 0) ? 5'd4 : 5'd3;
      ea = (i % 2 == 0) ? 32'd23 : 32'd42;
      eb = (i % 2 == 0) ? 32'd42 : 32'd23;
      drive(1'b1, a, b, 2'(i), (i == 0), 5'd3, 32'd23, 1'b1);
      step();
      check_slot($sformatf("tput%0d", i), 1'b1, ea, eb, 2'(i));
      check($sformatf("tput%0d.issue_ready", i), {31'd0, issue_ready}, 32'd1);
    end

    // Consume with nothing behind it: slot empties, operands hold their last values.
    drive(1'b0, 5'd5, 5'd5, 2'b00, 1'b0, 5'd0, 32'd0, 1'b1);
    step();
    check_slot("drain", 1'b0, 32'd42, 32'd23, 2'b11);
    op_ready = 1'b0;
    #1;
    check("drain.issue_ready", {31'd0, issue_ready}, 32'd1);

    // Reset mid-operation: slot full, writeback and issue active at the reset edge.
    drive(1'b1, 5'd3, 5'd4, 2'b10, 1'b0, 5'd0, 32'd0, 1'b0);
    step();
    check("premid.op_valid", {31'd0, op_valid}, 32'd1);
    reset = 1'b1;
    drive(1'b1, 5'd6, 5'd3, 2'b11, 1'b1, 5'd6, 32'd77, 1'b1);
    step();
    reset = 1'b0;
    check_slot("midreset", 1'b0, 32'd0, 32'd0, 2'b00);
    drive(1'b1, 5'd6, 5'd3, 2'b10, 1'b0, 5'd0, 32'd0, 1'b1);
    step();
    check_slot("postreset", 1'b1, 32'd0, 32'd0, 2'b10);
    drive(1'b1, 5'd6, 5'd4, 2'b01, 1'b1, 5'd6, 32'd5, 1'b1);
    step();
    check_slot("postreset_wb", 1'b1, 32'd5, 32'd0, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
